msx_slot_select: RTL and testbench
==================================

// Module: msx_slot_select
// PURPOSE
// Parametrised primary/secondary slot selector for the MSX memory map. Holds PPI primary-slot register (I/O A8h) and
// per-slot subslot expander registers (mem FFFFh), decodes each CPU access to {slot,subslot,page}, and presents a
// registered layout index + valid strobe to the slot_layout lookup. Sits between the T80 bus and the slot/mapper fabric.
// PARAMETERS
// SLOTS     4       number of populated primary slots (1..4); slots >= SLOTS are absent
// PSL_PORT  8'hA8   I/O port of primary-slot register
// EXP_ADDR  16'hFFFF memory address of expander register
// PORTS
// clk          in   1   system clock
// reset_n      in   1   synchronous reset, active low
// cpu_addr     in   16  CPU address
// cpu_dout     in   8   CPU write data
// cpu_wr       in   1   CPU write (level, may span several clk)
// cpu_rd       in   1   CPU read
// cpu_mreq     in   1   memory request
// cpu_iorq     in   1   I/O request
// cpu_m1       in   1   M1 cycle (IORQ&M1 = INTA, never decoded)
// exp_en       in   4   per-slot expander present (bit n = slot n)
// exp_mask     in   4   per-slot expander register enable (0 = FFFFh passes to memory)
// cpu_din      out  8   read data, 8'hFF when not driving (AND-bus)
// psl_reg      out  8   primary-slot register
// active_slot  out  2   slot of current page (combinational)
// layout_id    out  6   registered {slot,subslot,page}
// layout_valid out  1   registered: layout_id belongs to a live mem access
// exp_hit      out  1   current access is expander register; memory must be suppressed
// slot_absent  out  1   current page maps to slot >= SLOTS; memory suppressed, reads FFh
// sel_changed  out  1   (SLOT_SEL_TRACE_EN only) one-cycle pulse on any slot/subslot register change
// sel_count    out  8   (SLOT_SEL_TRACE_EN only) saturating count of register changes
// BEHAVIOUR
// - Reset (reset_n=0 at clk edge): psl_reg=0, all exp regs=0, layout_id=0, layout_valid=0, sel_count=0, sel_changed=0.
// - page=cpu_addr[15:14]; active_slot=psl_reg[2*page+:2]; subslot=exp_en[slot]?exp_reg[slot][2*page+:2]:2'd0.
// - io_wr = iorq&~m1&wr&addr[7:0]==PSL_PORT; io_rd likewise with rd. exp_sel = mreq&addr==EXP_ADDR&exp_en[slot]&exp_mask[slot].
// - exp_hit = exp_sel&(rd|wr). slot_absent = mreq&(active_slot>=SLOTS)&~exp_hit.
// - Writes commit on first clk where strobe true and previous-cycle strobe false (edge detect); held wr = one write.
// - io_wr -> psl_reg<=cpu_dout. exp write -> exp_reg[active_slot]<=cpu_dout (slot from page 3 at time of write).
// - New register value visible to decode/readback from the cycle after commit.
// - cpu_din: io_rd -> psl_reg; exp_sel&rd -> ~exp_reg[active_slot]; slot_absent&rd -> FFh; else FFh. Combinational.
// - mreq&iorq both high: illegal; no register update, cpu_din=FFh, layout_valid<=0.
// - layout_id<= {active_slot,subslot,page} every clk; layout_valid<= mreq&(rd|wr)&~exp_hit&~slot_absent. Latency 1 clk.
// - exp_en=0 for a slot: FFFFh is plain memory, exp_reg of that slot frozen, subslot=0.
// - Reset mid-write: reset wins; edge detector cleared, held wr after reset release counts as a new edge.
// CONFIGURATION
// SLOT_SEL_TRACE_EN defined: sel_changed pulses 1 clk after any committed write whose data differs from old value;
//   sel_count increments per pulse, saturates at 8'hFF. Undefined: ports tie to 0, no counter logic.
// TESTING
// - Reset, then io_wr A8h=8'hE4 -> psl_reg=E4, page0..3 active_slot=0,1,2,3.
// - psl_reg=C0, exp_en=4'h8, mask=4'h8, mem wr FFFFh=8'h5A held 3 clk -> one write, read FFFFh=A5, exp_hit=1.
// - Same setup, access 4000h -> layout_id={2'd0,2'd0,2'd1} one clk after, layout_valid=1; access C000h -> {3,1,3}.
// - SLOTS=2, psl_reg=30, rd at 8000h -> slot_absent=1, cpu_din=FF, layout_valid=0.
// - exp_mask[3]=0, wr FFFFh -> exp_hit=0, exp_reg unchanged, layout_valid=1 (plain RAM write).
// - TRACE_EN: write A8h with same value twice then new value -> one sel_changed pulse, sel_count=1; reset mid-wr -> count=0.

Source files
------------

// File: rtl/msx_slot_select.sv
// -----------------------------------------------------------------------------
// msx_slot_select
//
// Purpose:
//   Primary/secondary slot selector for the MSX memory map. Holds the PPI
//   primary-slot register (I/O port PSL_PORT) and one subslot expander register
//   per primary slot (memory address EXP_ADDR). Each CPU access is decoded to
//   {slot, subslot, page}. A registered layout index and a valid strobe are
//   presented to the slot_layout lookup one clock after the access.
//
// Optional feature (macro SLOT_SEL_TRACE_EN):
//   When defined, sel_changed pulses for one clock after any committed register
//   write that changes the stored value. sel_count is a saturating count of
//   those pulses. When undefined, both outputs are tied to zero.
//
// Parameters:
//   SLOTS     number of populated primary slots (1..4); slots >= SLOTS are absent
//   PSL_PORT  I/O port of the primary-slot register
//   EXP_ADDR  memory address of the expander register
//
// Ports:
//   clk          system clock
//   reset_n      synchronous reset, active low
//   cpu_addr     CPU address
//   cpu_dout     CPU write data
//   cpu_wr       CPU write strobe (level, may span several clocks)
//   cpu_rd       CPU read strobe
//   cpu_mreq     memory request
//   cpu_iorq     I/O request
//   cpu_m1       M1 cycle (IORQ with M1 is an interrupt acknowledge)
//   exp_en       per-slot expander present
//   exp_mask     per-slot expander register enable
//   cpu_din      read data, FFh when not driving (AND-bus)
//   psl_reg      primary-slot register
//   active_slot  slot of the current page (combinational)
//   layout_id    registered {slot, subslot, page}
//   layout_valid registered: layout_id belongs to a live memory access
//   exp_hit      current access targets the expander register
//   slot_absent  current page maps to an unpopulated slot
//   sel_changed  one-clock pulse on a slot/subslot register change (trace only)
//   sel_count    saturating count of register changes (trace only)
// -----------------------------------------------------------------------------
module msx_slot_select #(
  parameter int          SLOTS    = 4,
  parameter logic [7:0]  PSL_PORT = 8'hA8,
  parameter logic [15:0] EXP_ADDR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic        cpu_mreq,
  input  logic        cpu_iorq,
  input  logic        cpu_m1,
  input  logic [3:0]  exp_en,
  input  logic [3:0]  exp_mask,
  output logic [7:0]  cpu_din,
  output logic [7:0]  psl_reg,
  output logic [1:0]  active_slot,
  output logic [5:0]  layout_id,
  output logic        layout_valid,
  output logic        exp_hit,
  output logic        slot_absent,
  output logic        sel_changed,
  output logic [7:0]  sel_count
);

  localparam logic [2:0] SLOT_LIMIT = 3'(SLOTS);

  logic [7:0] exp_reg [4];
  logic [1:0] page;
  logic [1:0] subslot;
  logic       illegal;
  logic       io_wr;
  logic       io_rd;
  logic       exp_sel;
  logic       exp_wr;
  logic       io_wr_q;
  logic       exp_wr_q;
  logic       io_commit;
  logic       exp_commit;

  // Address decode. MREQ and IORQ together is an illegal bus state: it
  // blocks register updates and readback but leaves the layout decode alone.
  always_comb begin
    page        = cpu_addr[15:14];
    active_slot = psl_reg[{page, 1'b0} +: 2];
    subslot     = exp_en[active_slot] ? exp_reg[active_slot][{page, 1'b0} +: 2] : 2'd0;
    illegal     = cpu_mreq & cpu_iorq;
    io_wr       = cpu_iorq & ~cpu_m1 & cpu_wr & (cpu_addr[7:0] == PSL_PORT) & ~illegal;
    io_rd       = cpu_iorq & ~cpu_m1 & cpu_rd & (cpu_addr[7:0] == PSL_PORT) & ~illegal;
    exp_sel     = cpu_mreq & (cpu_addr == EXP_ADDR) & exp_en[active_slot] & exp_mask[active_slot];
    exp_wr      = exp_sel & cpu_wr & ~illegal;
    exp_hit     = exp_sel & (cpu_rd | cpu_wr);
    slot_absent = cpu_mreq & ({1'b0, active_slot} >= SLOT_LIMIT) & ~exp_hit;
    // A write strobe held over several clocks commits only on its first clock.
    io_commit   = io_wr & ~io_wr_q;
    exp_commit  = exp_wr & ~exp_wr_q;
  end

  // Read mux. The expander register reads back inverted, as on real hardware.
  always_comb begin
    cpu_din = 8'hFF;
    if (!illegal) begin
      if (io_rd) begin
        cpu_din = psl_reg;
      end else if (exp_sel && cpu_rd) begin
        cpu_din = ~exp_reg[active_slot];
      end
    end
  end

  // Register file, edge detectors and layout pipeline. The expander write
  // targets the slot selected for page 3 at the time of the write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      psl_reg      <= 8'h00;
      for (int i = 0; i < 4; i++) begin
        exp_reg[i] <= 8'h00;
      end
      io_wr_q      <= 1'b0;
      exp_wr_q     <= 1'b0;
      layout_id    <= 6'd0;
      layout_valid <= 1'b0;
    end else begin
      io_wr_q      <= io_wr;
      exp_wr_q     <= exp_wr;
      if (io_commit) begin
        psl_reg <= cpu_dout;
      end
      if (exp_commit) begin
        exp_reg[active_slot] <= cpu_dout;
      end
      layout_id    <= {active_slot, subslot, page};
      layout_valid <= cpu_mreq & ~cpu_iorq & (cpu_rd | cpu_wr) & ~exp_hit & ~slot_absent;
    end
  end

`ifdef SLOT_SEL_TRACE_EN
  logic changed;

  assign changed = (io_commit && (cpu_dout != psl_reg)) ||
                   (exp_commit && (cpu_dout != exp_reg[active_slot]));

  // Change tracing: the pulse and the count step together at the commit edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_changed <= 1'b0;
      sel_count   <= 8'h00;
    end else begin
      sel_changed <= changed;
      if (changed && (sel_count != 8'hFF)) begin
        sel_count <= sel_count + 8'd1;
      end
    end
  end
`else
  assign sel_changed = 1'b0;
  assign sel_count   = 8'h00;
`endif

endmodule

// File: tb/tb_msx_slot_select.sv
// -----------------------------------------------------------------------------
// tb_msx_slot_select
//
// Self-checking bench for msx_slot_select. A default instance (SLOTS=4) is
// checked through a scoreboard of expected layout results. A second instance
// (SLOTS=2) shares the same stimulus and covers absent-slot decoding.
// Define SLOT_SEL_TRACE_EN to also check the trace outputs.
// -----------------------------------------------------------------------------
module tb_msx_slot_select;

  typedef struct packed {
    logic       valid;
    logic [5:0] id;
  } layout_t;

`ifdef SLOT_SEL_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic        cpu_mreq = 1'b0;
  logic        cpu_iorq = 1'b0;
  logic        cpu_m1 = 1'b0;
  logic [3:0]  exp_en = 4'h0;
  logic [3:0]  exp_mask = 4'h0;

  logic [7:0]  cpu_din, psl_reg, sel_count;
  logic [1:0]  active_slot;
  logic [5:0]  layout_id;
  logic        layout_valid, exp_hit, slot_absent, sel_changed;

  logic [7:0]  d2_cpu_din, d2_psl_reg, d2_sel_count;
  logic [1:0]  d2_active_slot;
  logic [5:0]  d2_layout_id;
  logic        d2_layout_valid, d2_exp_hit, d2_slot_absent, d2_sel_changed;

  int checks = 0;
  int errors = 0;

  layout_t sb_queue[$];

  // Reference model state.
  logic [7:0] m_psl;
  logic [7:0] m_exp [4];
  logic       m_io_prev, m_exp_prev;
  logic       m_changed;
  logic [7:0] m_count;
  logic       p_io_wr, p_exp_wr;
  logic [1:0] p_slot;

  msx_slot_select dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_mreq(cpu_mreq), .cpu_iorq(cpu_iorq),
    .cpu_m1(cpu_m1), .exp_en(exp_en), .exp_mask(exp_mask), .cpu_din(cpu_din),
    .psl_reg(psl_reg), .active_slot(active_slot), .layout_id(layout_id),
    .layout_valid(layout_valid), .exp_hit(exp_hit), .slot_absent(slot_absent),
    .sel_changed(sel_changed), .sel_count(sel_count)
  );

  msx_slot_select #(.SLOTS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_mreq(cpu_mreq), .cpu_iorq(cpu_iorq),
    .cpu_m1(cpu_m1), .exp_en(exp_en), .exp_mask(exp_mask), .cpu_din(d2_cpu_din),
    .psl_reg(d2_psl_reg), .active_slot(d2_active_slot), .layout_id(d2_layout_id),
    .layout_valid(d2_layout_valid), .exp_hit(d2_exp_hit), .slot_absent(d2_slot_absent),
    .sel_changed(d2_sel_changed), .sel_count(d2_sel_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
    end
  endtask

  // Drive one bus cycle at the falling edge and push the layout result the
  // model expects to see after the next rising edge.
  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] dout,
                               input logic wr, input logic rd, input logic mreq,
                               input logic iorq, input logic m1);
    logic [1:0] pg, slot, sub;
    logic       sel, hit, valid;
    @(negedge clk);
    cpu_addr = addr; cpu_dout = dout; cpu_wr = wr; cpu_rd = rd;
    cpu_mreq = mreq; cpu_iorq = iorq; cpu_m1 = m1;
    pg    = addr[15:14];
    slot  = m_psl[{pg, 1'b0} +: 2];
    sub   = exp_en[slot] ? m_exp[slot][{pg, 1'b0} +: 2] : 2'd0;
    sel   = mreq && (addr == 16'hFFFF) && exp_en[slot] && exp_mask[slot];
    hit   = sel && (rd || wr);
    valid = mreq && !iorq && (rd || wr) && !hit;
    if (!reset_n) sb_queue.push_back('{valid: 1'b0, id: 6'd0});
    else          sb_queue.push_back('{valid: valid, id: {slot, sub, pg}});
    p_io_wr  = iorq && !mreq && !m1 && wr && (addr[7:0] == 8'hA8);
    p_exp_wr = sel && wr && !iorq;
    p_slot   = slot;
  endtask

  // Advance one clock: update the model, then pop and compare the scoreboard.
  task automatic tick();
    layout_t e;
    logic    chg;
    @(posedge clk);
    if (!reset_n) begin
      m_psl = 8'h00;
      for (int i = 0; i < 4; i++) m_exp[i] = 8'h00;
      m_io_prev = 1'b0; m_exp_prev = 1'b0; m_changed = 1'b0; m_count = 8'h00;
    end else begin
      chg = 1'b0;
      if (p_io_wr && !m_io_prev) begin
        chg   = (cpu_dout != m_psl);
        m_psl = cpu_dout;
      end
      if (p_exp_wr && !m_exp_prev) begin
        chg = chg || (cpu_dout != m_exp[p_slot]);
        m_exp[p_slot] = cpu_dout;
      end
      m_io_prev  = p_io_wr;
      m_exp_prev = p_exp_wr;
      m_changed  = chg;
      if (chg && m_count != 8'hFF) m_count = m_count + 8'd1;
    end
    #1;
    if (sb_queue.size() == 0) begin
      checkOutput("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_queue.pop_front();
      checkOutput("layout_valid", 32'(layout_valid), 32'(e.valid));
      checkOutput("layout_id", 32'(layout_id), 32'(e.id));
    end
    checkOutput("psl_reg", 32'(psl_reg), 32'(m_psl));
    checkOutput("sel_changed", 32'(sel_changed), TRACE ? 32'(m_changed) : 32'd0);
    checkOutput("sel_count", 32'(sel_count), TRACE ? 32'(m_count) : 32'd0);
  endtask

  task automatic idle();
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic ioWrite(input logic [7:0] data);
    applyStimulus(16'h00A8, data, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
  endtask

  initial begin
    m_psl = 8'h00;
    for (int i = 0; i < 4; i++) m_exp[i] = 8'h00;
    m_io_prev = 1'b0; m_exp_prev = 1'b0; m_changed = 1'b0; m_count = 8'h00;
    p_io_wr = 1'b0; p_exp_wr = 1'b0; p_slot = 2'd0;

    // Reset state.
    reset_n = 1'b0;
    idle();
    idle();
    checkOutput("reset_psl", 32'(psl_reg), 32'd0);
    checkOutput("reset_valid", 32'(layout_valid), 32'd0);
    reset_n = 1'b1;
    idle();

    // Primary slot register write and per-page slot decode.
    ioWrite(8'hE4);
    checkOutput("psl_E4", 32'(psl_reg), 32'hE4);
    for (int p = 0; p < 4; p++) begin
      applyStimulus(16'(p << 14), 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      #1 checkOutput("active_slot", 32'(active_slot), 32'(p));
      tick();
    end
    applyStimulus(16'h00A8, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1 checkOutput("io_read", 32'(cpu_din), 32'hE4);
    tick();

    // Interrupt acknowledge never reaches the register.
    applyStimulus(16'h00A8, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    idle();
    checkOutput("inta_psl", 32'(psl_reg), 32'hE4);

    // Expander write held three clocks; later data must not land.
    ioWrite(8'hC0);
    exp_en = 4'h8; exp_mask = 4'h8;
    applyStimulus(16'hFFFF, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("exp_hit_wr", 32'(exp_hit), 32'd1);
    tick();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(16'hFFFF, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    idle();
    applyStimulus(16'hFFFF, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("exp_read", 32'(cpu_din), 32'hA5);
    checkOutput("exp_hit_rd", 32'(exp_hit), 32'd1);
    tick();

    // Layout decode through the expander.
    applyStimulus(16'h4000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("layout_4000", 32'(layout_id), 32'({2'd0, 2'd0, 2'd1}));
    applyStimulus(16'hC000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("layout_C000", 32'(layout_id), 32'({2'd3, 2'd1, 2'd3}));

    // Masked expander: FFFFh is plain RAM.
    exp_mask = 4'h0;
    applyStimulus(16'hFFFF, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("masked_hit", 32'(exp_hit), 32'd0);
    tick();
    checkOutput("masked_valid", 32'(layout_valid), 32'd1);
    idle();
    exp_mask = 4'h8;
    applyStimulus(16'hFFFF, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("masked_keep", 32'(cpu_din), 32'hA5);
    tick();

    // Illegal MREQ+IORQ: no update, FFh read, no valid layout.
    applyStimulus(16'h00A8, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(16'h00A8, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    #1 checkOutput("illegal_din", 32'(cpu_din), 32'hFF);
    tick();
    checkOutput("illegal_psl", 32'(psl_reg), 32'hC0);

    // Absent slots on the SLOTS=2 instance.
    ioWrite(8'h30);
    applyStimulus(16'h8000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("absent_8000", 32'(d2_slot_absent), 32'd1);
    checkOutput("absent_din", 32'(d2_cpu_din), 32'hFF);
    checkOutput("present_4", 32'(slot_absent), 32'd0);
    tick();
    checkOutput("absent_valid", 32'(d2_layout_valid), 32'd0);
    ioWrite(8'h24);
    applyStimulus(16'h4000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("slot1_present", 32'(d2_slot_absent), 32'd0);
    tick();
    checkOutput("slot1_valid", 32'(d2_layout_valid), 32'd1);
    applyStimulus(16'h8000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("slot2_absent", 32'(d2_slot_absent), 32'd1);
    tick();

    // Same-value writes do not count as changes; a new value does.
    reset_n = 1'b0;
    idle();
    reset_n = 1'b1;
    ioWrite(8'h00);
    ioWrite(8'h00);
    ioWrite(8'h07);
    checkOutput("trace_count", 32'(sel_count), TRACE ? 32'd1 : 32'd0);

    // Reset during a held write; the held strobe is a new edge afterwards.
    applyStimulus(16'h00A8, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    reset_n = 1'b0;
    applyStimulus(16'h00A8, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("rst_mid_psl", 32'(psl_reg), 32'd0);
    checkOutput("rst_mid_count", 32'(sel_count), 32'd0);
    reset_n = 1'b1;
    applyStimulus(16'h00A8, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("rst_new_edge", 32'(psl_reg), 32'h11);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
